// File: rtl/difftest_step_arbiter.sv
// Serialises per-core difftest step counts onto one checker request/response port,
// keeps a sticky simulation verdict and per-core stuck/overflow monitors.
module difftest_step_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int STEP_W    = 8,
  parameter int CNT_W     = 16,
  parameter int STUCK_W   = 32,
  localparam int CORE_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_CORES*STEP_W-1:0] core_step,
  input  logic [STUCK_W-1:0]          stuck_limit,
  output logic                        chk_req_valid,
  input  logic                        chk_req_ready,
  output logic [CORE_W-1:0]           chk_req_core,
  output logic [STEP_W-1:0]           chk_req_nstep,
  input  logic                        chk_rsp_valid,
  input  logic [7:0]                  chk_rsp_result,
  output logic [7:0]                  result,
  output logic [NUM_CORES-1:0]        stuck,
  output logic                        overflow,
  output logic                        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   NSTEP_MAX = CNT_W'({STEP_W{1'b1}});
  localparam logic [STUCK_W-1:0] TIMER_MAX = {STUCK_W{1'b1}};
  localparam logic [7:0]         RES_RUN   = 8'd0;
  localparam logic [7:0]         RES_DONE  = 8'd1;
  localparam logic [7:0]         RES_FAIL  = 8'd2;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     pending_q [NUM_CORES];
  logic [CNT_W-1:0]     pending_d [NUM_CORES];
  logic [CNT_W:0]       sum_s     [NUM_CORES];
  logic [CNT_W-1:0]     sub_s     [NUM_CORES];
  logic [STUCK_W-1:0]   timer_q   [NUM_CORES];
  logic [STUCK_W-1:0]   timer_d   [NUM_CORES];
  logic [CORE_W-1:0]    rr_q, rr_d;
  logic [CORE_W-1:0]    req_core_q, req_core_d;
  logic [STEP_W-1:0]    req_nstep_q, req_nstep_d;
  logic                 req_valid_q, req_valid_d;
  logic                 busy_q, busy_d;
  logic [7:0]           result_q, result_d;
  logic [NUM_CORES-1:0] stuck_q, stuck_d;
  logic                 overflow_q, overflow_d;

  logic                 grant_vld_s;
  logic [CORE_W-1:0]    grant_core_s;
  logic [CORE_W-1:0]    cand_s;
  logic [CNT_W-1:0]     grant_amt_s;
  logic                 do_grant_s;
  logic                 ovf_evt_s;
  logic [7:0]           verdict_s;

  // Round-robin pick: scan from the highest offset down so the nearest non-empty core wins.
  always_comb begin
    grant_vld_s  = 1'b0;
    grant_core_s = '0;
    cand_s       = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      cand_s = CORE_W'((int'(rr_q) + k) % NUM_CORES);
      if (pending_q[cand_s] != '0) begin
        grant_vld_s  = 1'b1;
        grant_core_s = cand_s;
      end else begin
        grant_vld_s  = grant_vld_s;
      end
    end
    if (pending_q[grant_core_s] > NSTEP_MAX) begin
      grant_amt_s = NSTEP_MAX;
    end else begin
      grant_amt_s = pending_q[grant_core_s];
    end
    do_grant_s = (state_q == S_IDLE) && (result_q == RES_RUN) && grant_vld_s;
  end

  // Pending-step accumulators: subtract the grant, add new steps, saturate at CNT_MAX.
  always_comb begin
    ovf_evt_s = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (do_grant_s && (grant_core_s == CORE_W'(i))) begin
        sub_s[i] = pending_q[i] - grant_amt_s;
      end else begin
        sub_s[i] = pending_q[i];
      end
      sum_s[i] = {1'b0, sub_s[i]} + (CNT_W + 1)'(core_step[i*STEP_W +: STEP_W]);
      if (sum_s[i] > {1'b0, CNT_MAX}) begin
        pending_d[i] = CNT_MAX;
        ovf_evt_s    = 1'b1;
      end else begin
        pending_d[i] = sum_s[i][CNT_W-1:0];
      end
    end
  end

  // Stuck timers and sticky stuck flags, evaluated on the timer's next value.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_step[i*STEP_W +: STEP_W] != '0) begin
        timer_d[i] = '0;
      end else if (timer_q[i] == TIMER_MAX) begin
        timer_d[i] = TIMER_MAX;
      end else begin
        timer_d[i] = timer_q[i] + {{(STUCK_W-1){1'b0}}, 1'b1};
      end
      stuck_d[i] = stuck_q[i] | ((stuck_limit != '0) && (timer_d[i] >= stuck_limit));
    end
  end

  // Request FSM next state, request fields and verdict.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    req_core_d  = req_core_q;
    req_nstep_d = req_nstep_q;
    verdict_s   = RES_RUN;
    case (state_q)
      S_IDLE: begin
        if (do_grant_s) begin
          req_core_d  = grant_core_s;
          req_nstep_d = grant_amt_s[STEP_W-1:0];
          rr_d        = (grant_core_s == CORE_W'(NUM_CORES - 1)) ? '0 : grant_core_s + 1'b1;
          state_d     = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (chk_req_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (!chk_rsp_valid) begin
          state_d = S_WAIT;
        end else if (chk_rsp_result == RES_RUN) begin
          state_d = S_IDLE;
        end else if (chk_rsp_result == RES_DONE) begin
          state_d   = S_HALT;
          verdict_s = RES_DONE;
        end else begin
          state_d   = S_HALT;
          verdict_s = RES_FAIL;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // FAIL is terminal; a DONE can only land on a still-running verdict.
    if (result_q == RES_FAIL) begin
      result_d = RES_FAIL;
    end else if (ovf_evt_s || (verdict_s == RES_FAIL)) begin
      result_d = RES_FAIL;
    end else if (verdict_s == RES_DONE) begin
      result_d = RES_DONE;
    end else begin
      result_d = result_q;
    end

    overflow_d  = overflow_q | ovf_evt_s;
    req_valid_d = (state_d == S_REQ);
    busy_d      = (state_d == S_REQ) || (state_d == S_WAIT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      req_core_q  <= '0;
      req_nstep_q <= '0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= RES_RUN;
      stuck_q     <= '0;
      overflow_q  <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        pending_q[i] <= '0;
        timer_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      req_core_q  <= req_core_d;
      req_nstep_q <= req_nstep_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
      stuck_q     <= stuck_d;
      overflow_q  <= overflow_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        pending_q[i] <= pending_d[i];
        timer_q[i]   <= timer_d[i];
      end
    end
  end

  assign chk_req_valid = req_valid_q;
  assign chk_req_core  = req_core_q;
  assign chk_req_nstep = req_nstep_q;
  assign result        = result_q;
  assign stuck         = stuck_q;
  assign overflow      = overflow_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_difftest_step_arbiter.sv
// Directed bench: a 2-core arbiter (grants, splitting, back-pressure, verdicts, stuck)
// and a 1-core, 4-bit-accumulator arbiter (single request, saturation).
module tb_difftest_step_arbiter;

  logic        clock;
  int          checks;
  int          errors;

  // Instance A: 2 cores, STEP_W 8, CNT_W 16, STUCK_W 32
  logic        a_rst;
  logic [15:0] a_core_step;
  logic [31:0] a_stuck_limit;
  logic        a_valid, a_ready, a_core, a_rsp_valid, a_overflow, a_busy;
  logic [7:0]  a_nstep, a_rsp_result, a_result;
  logic [1:0]  a_stuck;

  // Instance B: 1 core, STEP_W 4, CNT_W 4, STUCK_W 8
  logic        b_rst;
  logic [3:0]  b_core_step;
  logic [7:0]  b_stuck_limit;
  logic        b_valid, b_ready, b_core, b_rsp_valid, b_overflow, b_busy, b_stuck;
  logic [3:0]  b_nstep;
  logic [7:0]  b_rsp_result, b_result;

  difftest_step_arbiter #(.NUM_CORES(2), .STEP_W(8), .CNT_W(16), .STUCK_W(32)) dut_a (
    .clock(clock), .reset(a_rst), .core_step(a_core_step), .stuck_limit(a_stuck_limit),
    .chk_req_valid(a_valid), .chk_req_ready(a_ready), .chk_req_core(a_core),
    .chk_req_nstep(a_nstep), .chk_rsp_valid(a_rsp_valid), .chk_rsp_result(a_rsp_result),
    .result(a_result), .stuck(a_stuck), .overflow(a_overflow), .busy(a_busy)
  );

  difftest_step_arbiter #(.NUM_CORES(1), .STEP_W(4), .CNT_W(4), .STUCK_W(8)) dut_b (
    .clock(clock), .reset(b_rst), .core_step(b_core_step), .stuck_limit(b_stuck_limit),
    .chk_req_valid(b_valid), .chk_req_ready(b_ready), .chk_req_core(b_core),
    .chk_req_nstep(b_nstep), .chk_rsp_valid(b_rsp_valid), .chk_rsp_result(b_rsp_result),
    .result(b_result), .stuck(b_stuck), .overflow(b_overflow), .busy(b_busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check the pending request on A, then accept it, respond "continue" and step to the next grant edge.
  task automatic serve(input string tag, input int exp_core, input int exp_nstep, input bit stop_steps);
    chk({tag, "_valid"}, 32'(a_valid), 32'd1);
    chk({tag, "_core"},  32'(a_core),  32'(exp_core));
    chk({tag, "_nstep"}, 32'(a_nstep), 32'(exp_nstep));
    tick();
    a_rsp_valid  = 1'b1;
    a_rsp_result = 8'd0;
    tick();
    a_rsp_valid = 1'b0;
    if (stop_steps) a_core_step = 16'd0;
    tick();
  endtask

  initial begin
    clock = 1'b0;
    checks = 0;
    errors = 0;
    a_rst = 1'b0; a_core_step = 16'd0; a_stuck_limit = 32'd0; a_ready = 1'b0;
    a_rsp_valid = 1'b0; a_rsp_result = 8'd0;
    b_rst = 1'b0; b_core_step = 4'd0; b_stuck_limit = 8'd0; b_ready = 1'b0;
    b_rsp_valid = 1'b0; b_rsp_result = 8'd0;
    tick();
    tick();

    // B reset state
    chk("b_rst_result", 32'(b_result), 32'd0);
    chk("b_rst_valid", 32'(b_valid), 32'd0);
    chk("b_rst_busy", 32'(b_busy), 32'd0);
    chk("b_rst_ovf", 32'(b_overflow), 32'd0);

    // B single request of 3 steps
    b_rst = 1'b1; b_core_step = 4'd3; b_ready = 1'b1;
    tick();
    b_core_step = 4'd0;
    chk("t1_no_valid_yet", 32'(b_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(b_valid), 32'd1);
    chk("t1_core", 32'(b_core), 32'd0);
    chk("t1_nstep", 32'(b_nstep), 32'd3);
    chk("t1_busy_req", 32'(b_busy), 32'd1);
    tick();
    chk("t1_valid_drop", 32'(b_valid), 32'd0);
    chk("t1_busy_wait", 32'(b_busy), 32'd1);
    b_rsp_valid = 1'b1; b_rsp_result = 8'd0;
    tick();
    b_rsp_valid = 1'b0;
    chk("t1_busy_idle", 32'(b_busy), 32'd0);
    chk("t1_result", 32'(b_result), 32'd0);
    tick();
    tick();
    chk("t1_no_more_req", 32'(b_valid), 32'd0);
    chk("t1_stuck_disabled", 32'(b_stuck), 32'd0);

    // B accumulator saturation while a request is held
    b_ready = 1'b0; b_core_step = 4'd10;
    tick();
    chk("t6_ovf_a", 32'(b_overflow), 32'd0);
    tick();
    chk("t6_req_nstep", 32'(b_nstep), 32'd10);
    chk("t6_ovf_b", 32'(b_overflow), 32'd0);
    tick();
    b_core_step = 4'd0;
    chk("t6_ovf_set", 32'(b_overflow), 32'd1);
    chk("t6_ovf_result", 32'(b_result), 32'd2);
    b_ready = 1'b1;
    tick();
    b_rsp_valid = 1'b1; b_rsp_result = 8'd1;
    tick();
    b_rsp_valid = 1'b0;
    chk("t6_done_no_override", 32'(b_result), 32'd2);
    chk("t6_halt_busy", 32'(b_busy), 32'd0);
    chk("t6_halt_valid", 32'(b_valid), 32'd0);

    // A reset state, then stuck timing and back-pressure
    a_stuck_limit = 32'd10;
    tick();
    chk("a_rst_result", 32'(a_result), 32'd0);
    chk("a_rst_stuck", 32'(a_stuck), 32'd0);
    chk("a_rst_valid", 32'(a_valid), 32'd0);
    a_rst = 1'b1; a_core_step = {8'd0, 8'd1}; a_ready = 1'b0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      if (n == 5) begin
        chk("t4_hold5_valid", 32'(a_valid), 32'd1);
        chk("t4_hold5_nstep", 32'(a_nstep), 32'd1);
      end
    end
    chk("t6_stuck_cycle9", 32'(a_stuck), 32'd0);
    chk("t4_hold9_core", 32'(a_core), 32'd0);
    chk("t4_hold9_nstep", 32'(a_nstep), 32'd1);
    tick();
    chk("t6_stuck_cycle10", 32'(a_stuck), 32'b10);
    a_core_step = 16'd0; a_ready = 1'b1;
    serve("t4_first", 0, 1, 1'b0);
    serve("t4_next", 0, 9, 1'b0);
    chk("t4_idle", 32'(a_valid), 32'd0);

    // A fresh run: both cores step every cycle, grants alternate
    a_rst = 1'b0; a_stuck_limit = 32'd0;
    tick();
    chk("t2_rst_stuck", 32'(a_stuck), 32'd0);
    a_rst = 1'b1; a_core_step = {8'd1, 8'd1}; a_ready = 1'b1;
    tick();
    tick();
    serve("t2_g0", 0, 1, 1'b0);
    serve("t2_g1", 1, 4, 1'b0);
    serve("t2_g2", 0, 6, 1'b1);
    serve("t2_g3", 1, 6, 1'b0);
    serve("t2_g4", 0, 3, 1'b0);
    chk("t2_drained_valid", 32'(a_valid), 32'd0);
    chk("t2_drained_busy", 32'(a_busy), 32'd0);

    // A: 600 steps on core 0 split into 255/255/90
    a_ready = 1'b0; a_core_step = {8'd1, 8'd0};
    tick();
    a_core_step = {8'd0, 8'd200};
    tick();
    tick();
    tick();
    a_core_step = 16'd0; a_ready = 1'b1;
    serve("t3_c1", 1, 1, 1'b0);
    serve("t3_s0", 0, 255, 1'b0);
    serve("t3_s1", 0, 255, 1'b0);
    serve("t3_s2", 0, 90, 1'b0);
    chk("t3_no_zero_req", 32'(a_valid), 32'd0);

    // A: DONE verdict, halt, late response ignored
    a_core_step = {8'd2, 8'd0};
    tick();
    a_core_step = 16'd0;
    tick();
    chk("t5_req_core", 32'(a_core), 32'd1);
    chk("t5_req_nstep", 32'(a_nstep), 32'd2);
    tick();
    a_rsp_valid = 1'b1; a_rsp_result = 8'd1;
    tick();
    a_rsp_valid = 1'b0;
    chk("t5_done", 32'(a_result), 32'd1);
    chk("t5_halt_busy", 32'(a_busy), 32'd0);
    a_rsp_valid = 1'b1; a_rsp_result = 8'd5;
    tick();
    a_rsp_valid = 1'b0;
    chk("t5_late_rsp_ignored", 32'(a_result), 32'd1);
    a_core_step = {8'd0, 8'd3};
    tick();
    a_core_step = 16'd0;
    tick();
    tick();
    chk("t5_halt_no_req", 32'(a_valid), 32'd0);

    // A: FAIL verdict is sticky
    a_rst = 1'b0;
    tick();
    chk("t5_rst_result", 32'(a_result), 32'd0);
    a_rst = 1'b1; a_core_step = {8'd0, 8'd1};
    tick();
    a_core_step = 16'd0;
    tick();
    chk("t5b_req_core", 32'(a_core), 32'd0);
    tick();
    a_rsp_valid = 1'b1; a_rsp_result = 8'd2;
    tick();
    a_rsp_valid = 1'b1; a_rsp_result = 8'd1;
    chk("t5b_fail", 32'(a_result), 32'd2);
    tick();
    a_rsp_valid = 1'b0;
    chk("t5b_fail_sticky", 32'(a_result), 32'd2);
    chk("t5b_no_ovf", 32'(a_overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
